lsu_sram: RTL and testbench
===========================

# lsu_sram

AXI4-Lite data-memory slave for the multicycle core's load/store path. It accepts one read or one write transaction at a time. Each response is returned after a fixed, parameterised latency on the R or B channel that the LSU waits on, so the LSU's WAIT state sees a realistic multi-cycle memory. Accesses outside the mapped window get a DECERR response, and the memory is left untouched.

## Interface
- BASE_ADDR, 32'h8000_0000: first byte address of the mapped window.
- DEPTH_WORDS, 4096: number of 32-bit words; must be a power of two.
- READ_LAT, 1: extra wait cycles before a read response (0..15).
- WRITE_LAT, 1: extra wait cycles before a write response (0..15).

Ports:
- clk_i  in  1: clock, rising edge.
- rst_i  in  1: reset, asynchronous, active-high.
- araddr_i  in  32, arvalid_i  in  1, arready_o  out  1: read address channel.
- rdata_o  out  32, rresp_o  out  2, rvalid_o  out  1, rready_i  in  1: read data channel.
- awaddr_i  in  32, awvalid_i  in  1, awready_o  out  1: write address channel.
- wdata_i  in  32, wstrb_i  in  4, wvalid_i  in  1, wready_o  out  1: write data channel.
- bresp_o  out  2, bvalid_o  out  1, bready_i  in  1: write response channel.

## Operation
- Response codes: OKAY = 2'b00, DECERR = 2'b11.
- An address is in range iff (addr - BASE_ADDR) < 4*DEPTH_WORDS, computed as a 32-bit unsigned subtraction.
- Word index = (addr - BASE_ADDR)[log2(DEPTH_WORDS)+1:2]. addr[1:0] is ignored; the LSU selects the byte lanes.
- Memory contents are not reset.

States: IDLE, RD_WAIT, RD_RESP, WR_COLLECT, WR_WAIT, WR_RESP.

- **IDLE:**
  - arready_o=1.
  - awready_o = wready_o = ~arvalid_i, so a read wins a simultaneous request.
  - AR handshake: latch the address, load the counter with READ_LAT, go to RD_WAIT.
  - AW and W handshake together: latch both, load the counter with WRITE_LAT, go to WR_WAIT.
  - Only one of AW or W handshakes: latch it, go to WR_COLLECT.
- **WR_COLLECT:**
  - The ready is high only for the missing channel; arready_o=0.
  - When the missing handshake occurs, load WRITE_LAT and go to WR_WAIT.
- **RD_WAIT / WR_WAIT:**
  - The 4-bit counter decrements each cycle.
  - When the counter is 0, move to RD_RESP / WR_RESP on the next edge.
  - On that same edge, the read samples mem[index] into the rdata register, or the write commits the bytes enabled by wstrb.
  - Out-of-range accesses: rdata=0, no write, response DECERR.
- **RD_RESP:** rvalid_o=1 with rdata_o and rresp_o held stable until rready_i; on the handshake return to IDLE.
- **WR_RESP:** same as RD_RESP, using bvalid_o, bresp_o and bready_i.
- All readies are 0 in every state except IDLE and WR_COLLECT.
- rvalid_o and bvalid_o are never high in the same cycle.
- Address or data presented while the slave is busy are ignored until the slave returns to IDLE.

## Timing
- Reset (async assert):
  - state=IDLE; all valid and ready outputs forced to 0 while rst_i=1.
  - rdata_o=0, rresp_o=0, bresp_o=0.
- First ready appears in the first cycle after rst_i deasserts.
- Handshake in cycle T with LAT=L: the response valid rises in cycle T+L+2 (L+1 wait cycles, then RESP).
- Minimum turnaround, with the response accepted immediately: a new AR or AW is accepted in cycle T+L+3.
- Reset during WAIT aborts the transaction: an uncommitted write never reaches memory and no response is issued afterwards.
- Reset asserted in the same cycle as a ready/valid handshake: the transaction is discarded.

## Test plan
- **Write then read:** AW=0x8000_0010, W=0xDEAD_BEEF with strb 4'hF; then AR to the same address → bvalid with bresp 00, then rvalid with rdata 0xDEAD_BEEF and rresp 00.
- **Partial strobe:** write 0x1122_3344 with strb 4'hF, then 0xAAxx_xxBB with strb 4'b1001 → read returns 0xAA22_33BB.
- **Decode error:** AR at 0x7FFF_FFFC and AW/W at BASE+4*DEPTH_WORDS → rresp=11 with rdata=0, bresp=11; an in-range read afterwards still returns the old data.
- **Latency and arbitration:**
  - READ_LAT=3: arvalid and awvalid in the same cycle T → AR accepted, awready=0, rvalid rises at T+5; AW is accepted only after rready.
  - The same check with WRITE_LAT=0 requires bvalid exactly 2 cycles after the AW/W handshake.
- **Split write and backpressure:** W in cycle 0, AW in cycle 3 → WR_COLLECT holds; bvalid appears and stays high and stable while bready is held low for 4 cycles, then drops the cycle after bready.
- **Reset mid-operation:** assert rst_i during WR_WAIT of a write of 0x5555_5555 over 0x0 → after release no bvalid ever appears, and a read of that address returns 0x0.

Source files
------------

// File: rtl/lsu_sram.sv
// AXI4-Lite data-memory slave with fixed, parameterised read/write response latency.
// Serves one transaction at a time; out-of-window accesses return DECERR and leave memory untouched.
module lsu_sram #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned READ_LAT    = 1,
  parameter int unsigned WRITE_LAT   = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] araddr_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rvalid_o,
  input  logic        rready_i,
  input  logic [31:0] awaddr_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  output logic [1:0]  bresp_o,
  output logic        bvalid_o,
  input  logic        bready_i
);

  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_RESP, WR_COLLECT, WR_WAIT, WR_RESP
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        got_aw_q;
  logic        got_w_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        rvalid_q;
  logic [1:0]  bresp_q;
  logic        bvalid_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]      off_c;
  logic             in_range_c;
  logic [IDX_W-1:0] idx_c;
  logic             idle_c;
  logic             collect_c;
  logic             ar_hs_c;
  logic             aw_hs_c;
  logic             w_hs_c;
  logic             mem_we_c;

  // Address decode of the latched transaction address.
  always_comb begin
    off_c      = addr_q - BASE_ADDR;
    in_range_c = off_c < SPAN_BYTES;
    idx_c      = off_c[IDX_W+1:2];
  end

  // Readies depend on state only, except that a pending read blocks writes in IDLE.
  always_comb begin
    idle_c    = (state_q == IDLE) && !rst_i;
    collect_c = (state_q == WR_COLLECT) && !rst_i;
    arready_o = idle_c;
    awready_o = idle_c ? !arvalid_i : (collect_c && !got_aw_q);
    wready_o  = idle_c ? !arvalid_i : (collect_c && !got_w_q);
    ar_hs_c   = arvalid_i && arready_o;
    aw_hs_c   = awvalid_i && awready_o;
    w_hs_c    = wvalid_i && wready_o;
    mem_we_c  = (state_q == WR_WAIT) && (cnt_q == 4'd0) && in_range_c && !rst_i;
  end

  assign rdata_o  = rdata_q;
  assign rresp_o  = rresp_q;
  assign rvalid_o = rvalid_q;
  assign bresp_o  = bresp_q;
  assign bvalid_o = bvalid_q;

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem[idx_c][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      wstrb_q  <= 4'd0;
      got_aw_q <= 1'b0;
      got_w_q  <= 1'b0;
      rdata_q  <= 32'd0;
      rresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      bvalid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          got_aw_q <= aw_hs_c;
          got_w_q  <= w_hs_c;
          if (ar_hs_c) begin
            addr_q  <= araddr_i;
            cnt_q   <= 4'(READ_LAT);
            state_q <= RD_WAIT;
          end else begin
            if (aw_hs_c) addr_q <= awaddr_i;
            if (w_hs_c) begin
              wdata_q <= wdata_i;
              wstrb_q <= wstrb_i;
            end
            if (aw_hs_c && w_hs_c) begin
              cnt_q   <= 4'(WRITE_LAT);
              state_q <= WR_WAIT;
            end else if (aw_hs_c || w_hs_c) begin
              state_q <= WR_COLLECT;
            end
          end
        end
        WR_COLLECT: begin
          if (aw_hs_c) begin
            addr_q   <= awaddr_i;
            got_aw_q <= 1'b1;
          end
          if (w_hs_c) begin
            wdata_q <= wdata_i;
            wstrb_q <= wstrb_i;
            got_w_q <= 1'b1;
          end
          if ((aw_hs_c || got_aw_q) && (w_hs_c || got_w_q)) begin
            cnt_q   <= 4'(WRITE_LAT);
            state_q <= WR_WAIT;
          end
        end
        RD_WAIT: begin
          if (cnt_q == 4'd0) begin
            rdata_q  <= in_range_c ? mem[idx_c] : 32'd0;
            rresp_q  <= in_range_c ? RESP_OKAY : RESP_DECERR;
            rvalid_q <= 1'b1;
            state_q  <= RD_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RD_RESP: begin
          if (rready_i) begin
            rvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        WR_WAIT: begin
          // The memory commit happens on this same edge via mem_we_c.
          if (cnt_q == 4'd0) begin
            bresp_q  <= in_range_c ? RESP_OKAY : RESP_DECERR;
            bvalid_q <= 1'b1;
            state_q  <= WR_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        WR_RESP: begin
          if (bready_i) begin
            bvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_sram.sv
// Directed bench for lsu_sram (READ_LAT=3, WRITE_LAT=0): vector table plus
// hand-written arbitration, split-write/backpressure and reset-abort sequences.
module tb_lsu_sram;

  localparam int unsigned RL = 3;
  localparam int unsigned WL = 0;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] araddr_i;
  logic        arvalid_i;
  logic        arready_o;
  logic [31:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        rvalid_o;
  logic        rready_i;
  logic [31:0] awaddr_i;
  logic        awvalid_i;
  logic        awready_o;
  logic [31:0] wdata_i;
  logic [3:0]  wstrb_i;
  logic        wvalid_i;
  logic        wready_o;
  logic [1:0]  bresp_o;
  logic        bvalid_o;
  logic        bready_i;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[13];

  always #5 clk_i = ~clk_i;

  lsu_sram #(
    .BASE_ADDR  (32'h8000_0000),
    .DEPTH_WORDS(4096),
    .READ_LAT   (RL),
    .WRITE_LAT  (WL)
  ) u_dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .araddr_i (araddr_i),
    .arvalid_i(arvalid_i),
    .arready_o(arready_o),
    .rdata_o  (rdata_o),
    .rresp_o  (rresp_o),
    .rvalid_o (rvalid_o),
    .rready_i (rready_i),
    .awaddr_i (awaddr_i),
    .awvalid_i(awvalid_i),
    .awready_o(awready_o),
    .wdata_i  (wdata_i),
    .wstrb_i  (wstrb_i),
    .wvalid_i (wvalid_i),
    .wready_o (wready_o),
    .bresp_o  (bresp_o),
    .bvalid_o (bvalid_o),
    .bready_i (bready_i)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One complete transaction; response accepted as soon as it is seen.
  task automatic xact(input vec_t v, input string tag);
    int   n;
    logic rdy;
    logic vld;
    if (v.wr) begin
      awaddr_i = v.addr; wdata_i = v.wdata; wstrb_i = v.strb;
      awvalid_i = 1'b1; wvalid_i = 1'b1;
    end else begin
      araddr_i = v.addr; arvalid_i = 1'b1;
    end
    n = 0;
    @(negedge clk_i);
    rdy = v.wr ? (awready_o && wready_o) : arready_o;
    while (!rdy && n < 20) begin
      @(negedge clk_i);
      n++;
      rdy = v.wr ? (awready_o && wready_o) : arready_o;
    end
    check({tag, " accept"}, 32'(rdy), 32'd1);
    step();
    arvalid_i = 1'b0; awvalid_i = 1'b0; wvalid_i = 1'b0;
    if (!rdy) return;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
      vld = v.wr ? bvalid_o : rvalid_o;
    end while (!vld && n < 40);
    check({tag, " latency"}, 32'(n), v.wr ? 32'(WL + 2) : 32'(RL + 2));
    if (v.wr) begin
      check({tag, " bresp"}, 32'(bresp_o), 32'(v.resp));
      check({tag, " rvalid idle"}, 32'(rvalid_o), 32'd0);
      bready_i = 1'b1;
    end else begin
      check({tag, " rresp"}, 32'(rresp_o), 32'(v.resp));
      check({tag, " rdata"}, rdata_o, v.rdata);
      check({tag, " bvalid idle"}, 32'(bvalid_o), 32'd0);
      rready_i = 1'b1;
    end
    step();
    rready_i = 1'b0; bready_i = 1'b0;
  endtask

  function automatic vec_t rd(input logic [31:0] a, input logic [1:0] r, input logic [31:0] d);
    vec_t v;
    v = '{1'b0, a, 32'd0, 4'd0, r, d};
    return v;
  endfunction

  function automatic vec_t wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              input logic [1:0] r);
    vec_t v;
    v = '{1'b1, a, d, s, r, 32'd0};
    return v;
  endfunction

  initial begin
    vecs[0]  = wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00);
    vecs[1]  = rd(32'h8000_0010, 2'b00, 32'hDEAD_BEEF);
    vecs[2]  = wr(32'h8000_0020, 32'h1122_3344, 4'hF, 2'b00);
    vecs[3]  = wr(32'h8000_0020, 32'hAA55_66BB, 4'b1001, 2'b00);
    vecs[4]  = rd(32'h8000_0020, 2'b00, 32'hAA22_33BB);
    vecs[5]  = rd(32'h8000_0023, 2'b00, 32'hAA22_33BB);
    vecs[6]  = wr(32'h8000_0000, 32'h1234_5678, 4'hF, 2'b00);
    vecs[7]  = wr(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 2'b11);
    vecs[8]  = rd(32'h7FFF_FFFC, 2'b11, 32'd0);
    vecs[9]  = rd(32'h8000_0000, 2'b00, 32'h1234_5678);
    vecs[10] = wr(32'h8000_3FFF, 32'h0BAD_F00D, 4'hF, 2'b00);
    vecs[11] = rd(32'h8000_3FFC, 2'b00, 32'h0BAD_F00D);
    vecs[12] = rd(32'h8000_4000, 2'b11, 32'd0);

    rst_i = 1'b1;
    araddr_i = '0; arvalid_i = 1'b0; rready_i = 1'b0;
    awaddr_i = '0; awvalid_i = 1'b0; wdata_i = '0; wstrb_i = '0; wvalid_i = 1'b0;
    bready_i = 1'b0;

    // Reset state
    @(negedge clk_i);
    check("rst arready", 32'(arready_o), 32'd0);
    check("rst awready", 32'(awready_o), 32'd0);
    check("rst wready", 32'(wready_o), 32'd0);
    check("rst rvalid", 32'(rvalid_o), 32'd0);
    check("rst bvalid", 32'(bvalid_o), 32'd0);
    check("rst rdata", rdata_o, 32'd0);
    check("rst rresp", 32'(rresp_o), 32'd0);
    check("rst bresp", 32'(bresp_o), 32'd0);
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("post-rst arready", 32'(arready_o), 32'd1);
    check("post-rst awready", 32'(awready_o), 32'd1);
    step();

    for (int i = 0; i < 13; i++) xact(vecs[i], $sformatf("vec%0d", i));

    // Simultaneous AR and AW/W: read wins, write waits for the read response
    araddr_i = 32'h8000_0010; arvalid_i = 1'b1;
    awaddr_i = 32'h8000_0030; awvalid_i = 1'b1;
    wdata_i = 32'hCAFE_F00D; wstrb_i = 4'hF; wvalid_i = 1'b1;
    @(negedge clk_i);
    check("arb arready", 32'(arready_o), 32'd1);
    check("arb awready", 32'(awready_o), 32'd0);
    check("arb wready", 32'(wready_o), 32'd0);
    step();
    arvalid_i = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_i);
      check($sformatf("arb c%0d awready", c), 32'(awready_o), 32'd0);
      check($sformatf("arb c%0d rvalid", c), 32'(rvalid_o), 32'(c >= 5));
      if (c >= 5) check($sformatf("arb c%0d rdata", c), rdata_o, 32'hDEAD_BEEF);
      if (c == 6) rready_i = 1'b1;
      step();
    end
    rready_i = 1'b0;
    @(negedge clk_i);
    check("arb rvalid drop", 32'(rvalid_o), 32'd0);
    check("arb aw accept", 32'(awready_o && wready_o), 32'd1);
    step();
    awvalid_i = 1'b0; wvalid_i = 1'b0;
    @(negedge clk_i);
    check("arb bvalid early", 32'(bvalid_o), 32'd0);
    step();
    @(negedge clk_i);
    check("arb bvalid", 32'(bvalid_o), 32'd1);
    check("arb bresp", 32'(bresp_o), 32'd0);
    bready_i = 1'b1;
    step();
    bready_i = 1'b0;
    xact(rd(32'h8000_0030, 2'b00, 32'hCAFE_F00D), "arb readback");

    // Split write: W in cycle 0, AW in cycle 3, then 4 cycles of B backpressure
    wdata_i = 32'h0F0F_0F0F; wstrb_i = 4'hF; wvalid_i = 1'b1;
    @(negedge clk_i);
    check("split w accept", 32'(wready_o), 32'd1);
    step();
    wvalid_i = 1'b0;
    araddr_i = 32'h8000_0010; arvalid_i = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk_i);
      check($sformatf("split c%0d arready", c), 32'(arready_o), 32'd0);
      check($sformatf("split c%0d awready", c), 32'(awready_o), 32'd1);
      check($sformatf("split c%0d wready", c), 32'(wready_o), 32'd0);
      step();
    end
    arvalid_i = 1'b0;
    awaddr_i = 32'h8000_0040; awvalid_i = 1'b1;
    @(negedge clk_i);
    check("split aw accept", 32'(awready_o), 32'd1);
    step();
    awvalid_i = 1'b0;
    @(negedge clk_i);
    check("split bvalid early", 32'(bvalid_o), 32'd0);
    step();
    for (int c = 5; c <= 8; c++) begin
      @(negedge clk_i);
      check($sformatf("split c%0d bvalid", c), 32'(bvalid_o), 32'd1);
      check($sformatf("split c%0d bresp", c), 32'(bresp_o), 32'd0);
      check($sformatf("split c%0d rvalid", c), 32'(rvalid_o), 32'd0);
      step();
    end
    @(negedge clk_i);
    check("split bvalid at bready", 32'(bvalid_o), 32'd1);
    bready_i = 1'b1;
    step();
    bready_i = 1'b0;
    @(negedge clk_i);
    check("split bvalid drop", 32'(bvalid_o), 32'd0);
    step();
    xact(rd(32'h8000_0040, 2'b00, 32'h0F0F_0F0F), "split readback");

    // Reset during WR_WAIT aborts the write
    xact(wr(32'h8000_0050, 32'h0000_0000, 4'hF, 2'b00), "abort pre");
    awaddr_i = 32'h8000_0050; wdata_i = 32'h5555_5555; wstrb_i = 4'hF;
    awvalid_i = 1'b1; wvalid_i = 1'b1;
    @(negedge clk_i);
    check("abort accept", 32'(awready_o && wready_o), 32'd1);
    step();
    awvalid_i = 1'b0; wvalid_i = 1'b0;
    rst_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      check($sformatf("abort rst%0d arready", c), 32'(arready_o), 32'd0);
      check($sformatf("abort rst%0d awready", c), 32'(awready_o), 32'd0);
      check($sformatf("abort rst%0d bvalid", c), 32'(bvalid_o), 32'd0);
      check($sformatf("abort rst%0d rdata", c), rdata_o, 32'd0);
      step();
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    check("abort arready", 32'(arready_o), 32'd1);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("abort no bvalid %0d", c), 32'(bvalid_o), 32'd0);
      step();
      @(negedge clk_i);
    end
    step();
    xact(rd(32'h8000_0050, 2'b00, 32'h0000_0000), "abort readback");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
